laser_pair_search: RTL

Parameterised two-circle coverage search for the laser treatment path. It accepts a job of NPTS target points over a valid/ready stream. It finds the first-best single treatment circle, then refines a second circle by alternating anchor rescans. It reports the pair with a one-cycle DONE pulse, then rearms for the next job without reset.

---
 rtl/laser_pkg.sv | 44 ++++
 rtl/laser_pair_search_eval.sv | 42 ++++
 rtl/laser_pair_search.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_pkg.sv
// laser_pkg: FSM state encoding and coverage helpers shared by the
// laser_pair_search block and its combinational evaluator.
package laser_pkg;

    // Upper bound on points per job accepted by popcount.
    localparam int LASER_MAX_NPTS = 256;

    typedef enum logic [2:0] {
        LASER_CAPTURE = 3'd0,
        LASER_SINGLE  = 3'd1,
        LASER_SCAN    = 3'd2,
        LASER_EVAL    = 3'd3,
        LASER_DONE    = 3'd4
    } laser_state_e;

    // A point is covered when dx^2 + dy^2 <= radius^2; 33-bit sums cannot overflow.
    function automatic logic covers(input logic [15:0] cx, input logic [15:0] cy,
                                    input logic [15:0] px, input logic [15:0] py,
                                    input int radius);
        logic [15:0] dx;
        logic [15:0] dy;
        logic [32:0] dx_w;
        logic [32:0] dy_w;
        logic [32:0] dist_sq;
        logic [32:0] rad_sq;
        dx      = (cx >= px) ? (cx - px) : (px - cx);
        dy      = (cy >= py) ? (cy - py) : (py - cy);
        dx_w    = {17'd0, dx};
        dy_w    = {17'd0, dy};
        dist_sq = (dx_w * dx_w) + (dy_w * dy_w);
        rad_sq  = 33'(radius) * 33'(radius);
        return (dist_sq <= rad_sq);
    endfunction

    function automatic logic [15:0] popcount(input logic [LASER_MAX_NPTS-1:0] mask);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < LASER_MAX_NPTS; i++) begin
            n = n + {15'd0, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/laser_pair_search_eval.sv
// laser_cover_eval: combinational coverage of one candidate centre against
// every stored point, plus its count and its union count with the anchor.
module laser_cover_eval
    import laser_pkg::*;
#(
    parameter int NPTS    = 40,
    parameter int COORD_W = 4,
    parameter int RADIUS  = 4,
    parameter int CW      = 6
) (
    input  logic [2*COORD_W-1:0]            cand_i,
    input  logic [NPTS-1:0][COORD_W-1:0]    px_i,
    input  logic [NPTS-1:0][COORD_W-1:0]    py_i,
    input  logic [NPTS-1:0]                 anchor_mask_i,
    output logic [NPTS-1:0]                 mask_o,
    output logic [CW-1:0]                   count_o,
    output logic [CW-1:0]                   union_count_o
);

    logic [LASER_MAX_NPTS-1:0] mask_w_s;
    logic [LASER_MAX_NPTS-1:0] union_w_s;

    // Per-point coverage test for the current candidate, candidate = {cy, cx}.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < NPTS; i++) begin
            mask_o[i] = covers(16'(cand_i[COORD_W-1:0]), 16'(cand_i[2*COORD_W-1:COORD_W]),
                               16'(px_i[i]), 16'(py_i[i]), RADIUS);
        end
    end

    // Population counts of the candidate mask and of its union with the anchor.
    always_comb begin
        mask_w_s                 = '0;
        union_w_s                = '0;
        mask_w_s[NPTS-1:0]       = mask_o;
        union_w_s[NPTS-1:0]      = mask_o | anchor_mask_i;
        count_o                  = CW'(popcount(mask_w_s));
        union_count_o            = CW'(popcount(union_w_s));
    end

endmodule

// File: rtl/laser_pair_search.sv
// laser_pair_search: captures NPTS points, finds the best single circle, then
// refines a second circle by anchor rescans. COVER port exists with LASER_COVER_OUT_EN.
module laser_pair_search
    import laser_pkg::*;
#(
    parameter int NPTS     = 40,
    parameter int COORD_W  = 4,
    parameter int RADIUS   = 4,
    parameter int MAX_ITER = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic [COORD_W-1:0]          X,
    input  logic [COORD_W-1:0]          Y,
    output logic [COORD_W-1:0]          C1X,
    output logic [COORD_W-1:0]          C1Y,
    output logic [COORD_W-1:0]          C2X,
    output logic [COORD_W-1:0]          C2Y,
    output logic                        DONE
`ifdef LASER_COVER_OUT_EN
    ,
    output logic [$clog2(NPTS+1)-1:0]   COVER
`endif
);

    localparam int CW = $clog2(NPTS + 1);
    localparam int IW = 2 * COORD_W;
    localparam int PW = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] LAST_IDX = '1;

    localparam logic [2:0] ST_CAPTURE = LASER_CAPTURE;
    localparam logic [2:0] ST_SINGLE  = LASER_SINGLE;
    localparam logic [2:0] ST_SCAN    = LASER_SCAN;
    localparam logic [2:0] ST_EVAL    = LASER_EVAL;
    localparam logic [2:0] ST_DONE    = LASER_DONE;

    logic [2:0]                     state_q, state_d;
    logic [CW-1:0]                  k_q, k_d;
    logic [IW-1:0]                  cnt_q, cnt_d;
    logic [NPTS-1:0][COORD_W-1:0]   px_q, px_d, py_q, py_d;
    logic [IW-1:0]                  best_idx_q, best_idx_d;
    logic [CW-1:0]                  best_cov_q, best_cov_d;
    logic [NPTS-1:0]                best_mask_q, best_mask_d;
    logic [IW-1:0]                  a_q, a_d, b_q, b_d, anchor_q, anchor_d;
    logic [NPTS-1:0]                anchor_mask_q, anchor_mask_d;
    logic [CW-1:0]                  pair_cov_q, pair_cov_d;
    logic [CW-1:0]                  iter_best_q, iter_best_d;
    logic [IW-1:0]                  iter_idx_q, iter_idx_d;
    logic [NPTS-1:0]                iter_mask_q, iter_mask_d;
    logic [PW-1:0]                  pass_q, pass_d;
    logic [COORD_W-1:0]             c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic                           done_q, done_d;
`ifdef LASER_COVER_OUT_EN
    logic [CW-1:0]                  cover_q, cover_d;
`endif

    logic [NPTS-1:0]                cand_mask_s;
    logic [CW-1:0]                  cand_cnt_s;
    logic [CW-1:0]                  union_cnt_s;
    logic [IW-1:0]                  nb_idx_s;
    logic [CW-1:0]                  nb_cov_s;
    logic [NPTS-1:0]                nb_mask_s;

    laser_cover_eval #(
        .NPTS    (NPTS),
        .COORD_W (COORD_W),
        .RADIUS  (RADIUS),
        .CW      (CW)
    ) u_eval (
        .cand_i        (cnt_q),
        .px_i          (px_q),
        .py_i          (py_q),
        .anchor_mask_i (anchor_mask_q),
        .mask_o        (cand_mask_s),
        .count_o       (cand_cnt_s),
        .union_count_o (union_cnt_s)
    );

    // Running single-circle best including the current candidate (strict: lowest index wins ties).
    always_comb begin
        nb_idx_s  = best_idx_q;
        nb_cov_s  = best_cov_q;
        nb_mask_s = best_mask_q;
        if (cand_cnt_s > best_cov_q) begin
            nb_idx_s  = cnt_q;
            nb_cov_s  = cand_cnt_s;
            nb_mask_s = cand_mask_s;
        end else begin
            nb_idx_s  = best_idx_q;
        end
    end

    // Next-state logic for the capture / single / scan / eval / done sequence.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        px_d          = px_q;
        py_d          = py_q;
        best_idx_d    = best_idx_q;
        best_cov_d    = best_cov_q;
        best_mask_d   = best_mask_q;
        a_d           = a_q;
        b_d           = b_q;
        anchor_d      = anchor_q;
        anchor_mask_d = anchor_mask_q;
        pair_cov_d    = pair_cov_q;
        iter_best_d   = iter_best_q;
        iter_idx_d    = iter_idx_q;
        iter_mask_d   = iter_mask_q;
        pass_d        = pass_q;
        c1x_d         = c1x_q;
        c1y_d         = c1y_q;
        c2x_d         = c2x_q;
        c2y_d         = c2y_q;
        done_d        = 1'b0;
`ifdef LASER_COVER_OUT_EN
        cover_d       = cover_q;
`endif
        case (state_q)
            ST_CAPTURE: begin
                if (IN_VALID) begin
                    for (int i = 0; i < NPTS; i++) begin
                        if (k_q == CW'(i)) begin
                            px_d[i] = X;
                            py_d[i] = Y;
                        end else begin
                            px_d[i] = px_q[i];
                        end
                    end
                    if (k_q == CW'(NPTS - 1)) begin
                        state_d     = ST_SINGLE;
                        k_d         = '0;
                        cnt_d       = '0;
                        best_idx_d  = '0;
                        best_cov_d  = '0;
                        best_mask_d = '0;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            ST_SINGLE: begin
                best_idx_d  = nb_idx_s;
                best_cov_d  = nb_cov_s;
                best_mask_d = nb_mask_s;
                cnt_d       = cnt_q + IW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d       = ST_SCAN;
                    a_d           = nb_idx_s;
                    b_d           = nb_idx_s;
                    anchor_d      = nb_idx_s;
                    anchor_mask_d = nb_mask_s;
                    pair_cov_d    = nb_cov_s;
                    iter_best_d   = nb_cov_s;
                    iter_idx_d    = nb_idx_s;
                    iter_mask_d   = nb_mask_s;
                    pass_d        = '0;
                end else begin
                    state_d = ST_SINGLE;
                end
            end
            ST_SCAN: begin
                if ((cnt_q != anchor_q) && (union_cnt_s > iter_best_q)) begin
                    iter_best_d = union_cnt_s;
                    iter_idx_d  = cnt_q;
                    iter_mask_d = cand_mask_s;
                end else begin
                    iter_best_d = iter_best_q;
                end
                cnt_d = cnt_q + IW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_EVAL: begin
                if (iter_best_q > pair_cov_q) begin
                    a_d           = anchor_q;
                    b_d           = iter_idx_q;
                    pair_cov_d    = iter_best_q;
                    anchor_d      = iter_idx_q;
                    anchor_mask_d = iter_mask_q;
                    pass_d        = pass_q + PW'(1);
                end else begin
                    pass_d        = pass_q;
                end
                // Outputs load on the edge into DONE so they change together with the strobe.
                if ((iter_best_q > pair_cov_q) && (int'(pass_d) < MAX_ITER)) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    c1x_d   = a_d[COORD_W-1:0];
                    c1y_d   = a_d[IW-1:COORD_W];
                    c2x_d   = b_d[COORD_W-1:0];
                    c2y_d   = b_d[IW-1:COORD_W];
`ifdef LASER_COVER_OUT_EN
                    cover_d = pair_cov_d;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_CAPTURE;
                k_d     = '0;
            end
            default: begin
                state_d = ST_CAPTURE;
                k_d     = '0;
            end
        endcase
    end

    // State, storage and result registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_CAPTURE;
            k_q           <= '0;
            cnt_q         <= '0;
            px_q          <= '0;
            py_q          <= '0;
            best_idx_q    <= '0;
            best_cov_q    <= '0;
            best_mask_q   <= '0;
            a_q           <= '0;
            b_q           <= '0;
            anchor_q      <= '0;
            anchor_mask_q <= '0;
            pair_cov_q    <= '0;
            iter_best_q   <= '0;
            iter_idx_q    <= '0;
            iter_mask_q   <= '0;
            pass_q        <= '0;
            c1x_q         <= '0;
            c1y_q         <= '0;
            c2x_q         <= '0;
            c2y_q         <= '0;
            done_q        <= 1'b0;
`ifdef LASER_COVER_OUT_EN
            cover_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            px_q          <= px_d;
            py_q          <= py_d;
            best_idx_q    <= best_idx_d;
            best_cov_q    <= best_cov_d;
            best_mask_q   <= best_mask_d;
            a_q           <= a_d;
            b_q           <= b_d;
            anchor_q      <= anchor_d;
            anchor_mask_q <= anchor_mask_d;
            pair_cov_q    <= pair_cov_d;
            iter_best_q   <= iter_best_d;
            iter_idx_q    <= iter_idx_d;
            iter_mask_q   <= iter_mask_d;
            pass_q        <= pass_d;
            c1x_q         <= c1x_d;
            c1y_q         <= c1y_d;
            c2x_q         <= c2x_d;
            c2y_q         <= c2y_d;
            done_q        <= done_d;
`ifdef LASER_COVER_OUT_EN
            cover_q       <= cover_d;
`endif
        end
    end

    assign IN_READY = (state_q == ST_CAPTURE);
    assign DONE     = done_q;
    assign C1X      = c1x_q;
    assign C1Y      = c1y_q;
    assign C2X      = c2x_q;
    assign C2Y      = c2y_q;
`ifdef LASER_COVER_OUT_EN
    assign COVER    = cover_q;
`endif

endmodule
